// File: rtl/tb_sequencer_if.sv
// Bench-facing bundle of the test sequencer: completion/kick inputs and
// per-domain resets plus run status outputs.
interface tb_sequencer_if #(
  parameter int NumResets  = 4,
  parameter int CycleWidth = 32
);
  logic                  test_done;
  logic                  test_fail;
  logic                  kick;
  logic [NumResets-1:0]  dom_rst;
  logic [CycleWidth-1:0] cycle_count;
  logic [1:0]            state;
  logic [1:0]            status;
  logic                  finished;

  modport master (
    output test_done, test_fail, kick,
    input  dom_rst, cycle_count, state, status, finished
  );

  modport slave (
    input  test_done, test_fail, kick,
    output dom_rst, cycle_count, state, status, finished
  );
endinterface

// File: rtl/tb_sequencer.sv
// Bench sequencer: staggered per-domain reset release, cycle and idle
// watchdogs, pass/fail collection with drain, end-of-test flag.
//
// state   | meaning
// RESET   | counting rst-low edges, releasing dom_rst in index order
// RUN     | test running, watchdogs active
// DRAIN   | result latched, waiting DrainCycles edges
// END     | outputs frozen until rst
module tb_sequencer #(
  parameter int NumResets       = 4,
  parameter int ResetHoldCycles = 2,
  parameter int ResetStagger    = 1,
  parameter int CycleWidth      = 32,
  parameter int MaxCycleCount   = 1048576,
  parameter int IdleTimeout     = 0,
  parameter int DrainCycles     = 4,
  parameter int FinishOnEnd     = 1
) (
  input  logic           clk,
  input  logic           rst,
  tb_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_RESET = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_END = 2'd3} state_t;
  typedef enum logic [1:0] {ST_RUNNING = 2'd0, ST_PASS = 2'd1, ST_FAIL = 2'd2, ST_TIMEOUT = 2'd3} status_t;

  localparam int RLast = ResetHoldCycles + (NumResets - 1) * ResetStagger;
  localparam int SeqW  = $clog2(RLast + 1);
  localparam int IdlW  = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1;
  localparam int DrnW  = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;
  localparam logic [64:0] CountLimit = (65'd1 << CycleWidth) - 65'd1;

  if (65'(MaxCycleCount) > CountLimit) begin : g_bad_max
    $error("tb_sequencer: MaxCycleCount does not fit in cycle_count");
  end

  state_t                state_q;
  status_t               status_q;
  logic [SeqW-1:0]       seq_q;
  logic [IdlW-1:0]       idle_q;
  logic [DrnW-1:0]       drain_q;
  logic [SeqW-1:0]       seq_nxt;
  logic [IdlW-1:0]       idle_inc;
  logic [DrnW-1:0]       drain_nxt;
  logic [CycleWidth-1:0] cc_inc;
  logic                  cc_at_max;
  logic                  idle_expired;

  assign seq_nxt      = seq_q + SeqW'(1);
  assign drain_nxt    = drain_q + DrnW'(1);
  assign idle_inc     = (&idle_q) ? idle_q : idle_q + IdlW'(1);
  // Saturate rather than wrap so a runaway test never looks young again.
  assign cc_inc       = (&bus.cycle_count) ? bus.cycle_count : bus.cycle_count + CycleWidth'(1);
  assign cc_at_max    = (bus.cycle_count == CycleWidth'(MaxCycleCount));
  assign idle_expired = (IdleTimeout != 0) && (int'(idle_q) == IdleTimeout);

  assign bus.state  = state_q;
  assign bus.status = status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_RESET;
      status_q        <= ST_RUNNING;
      bus.dom_rst     <= '1;
      bus.cycle_count <= '0;
      bus.finished    <= 1'b0;
      seq_q           <= '0;
      idle_q          <= '0;
      drain_q         <= '0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          seq_q <= seq_nxt;
          for (int i = 0; i < NumResets; i++)
            bus.dom_rst[i] <= int'(seq_nxt) < ResetHoldCycles + i * ResetStagger;
          if (int'(seq_nxt) >= RLast) state_q <= S_RUN;
        end
        S_RUN: begin
          bus.cycle_count <= cc_inc;
          idle_q          <= bus.kick ? '0 : idle_inc;
          drain_q         <= '0;
          if (bus.test_fail || bus.test_done) begin
            status_q     <= bus.test_fail ? ST_FAIL : ST_PASS;
            state_q      <= (DrainCycles == 0) ? S_END : S_DRAIN;
            bus.finished <= (DrainCycles == 0);
          end else if (cc_at_max || idle_expired) begin
            status_q     <= ST_TIMEOUT;
            state_q      <= S_END;
            bus.finished <= 1'b1;
          end
        end
        S_DRAIN: begin
          bus.cycle_count <= cc_inc;
          drain_q         <= drain_nxt;
          if (bus.test_fail && status_q == ST_PASS) status_q <= ST_FAIL;
          if (int'(drain_nxt) >= DrainCycles) begin
            state_q      <= S_END;
            bus.finished <= 1'b1;
          end
        end
        S_END: begin
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  if (FinishOnEnd != 0) begin : g_finish
    always @(posedge clk) begin
      if (bus.finished) begin
        $display("tb_sequencer: status=%0d cycle_count=%0d", bus.status, bus.cycle_count);
        $finish;
      end
    end
  end
`endif
endmodule

// File: tb/tb_tb_sequencer.sv
// Bench for tb_sequencer: two instances (idle watchdog off / 8) checked every
// cycle against a rule-level model, plus literal scenario checks.
module tb_tb_sequencer;
  localparam int N     = 4;
  localparam int HOLD  = 2;
  localparam int STAG  = 1;
  localparam int CW    = 32;
  localparam int MAXC  = 100;
  localparam int DRAIN = 4;
  localparam int RLAST = HOLD + (N - 1) * STAG;
  localparam longint CC_SAT = (64'sd1 <<< CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_i = 1'b0, fail_i = 1'b0, kick_i = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tb_sequencer_if #(.NumResets(N), .CycleWidth(CW)) b0 ();
  tb_sequencer_if #(.NumResets(N), .CycleWidth(CW)) b1 ();
  assign b0.test_done = done_i;
  assign b0.test_fail = fail_i;
  assign b0.kick      = kick_i;
  assign b1.test_done = done_i;
  assign b1.test_fail = fail_i;
  assign b1.kick      = kick_i;

  tb_sequencer #(.NumResets(N), .ResetHoldCycles(HOLD), .ResetStagger(STAG), .CycleWidth(CW),
                 .MaxCycleCount(MAXC), .IdleTimeout(0), .DrainCycles(DRAIN), .FinishOnEnd(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  tb_sequencer #(.NumResets(N), .ResetHoldCycles(HOLD), .ResetStagger(STAG), .CycleWidth(CW),
                 .MaxCycleCount(MAXC), .IdleTimeout(8), .DrainCycles(DRAIN), .FinishOnEnd(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rule-level model: phase 0..3, edges seen with rst low, counters as integers.
  int     m_n[2], m_ph[2], m_idle[2], m_drn[2], m_st[2], m_fin[2];
  longint m_cc[2];
  int     idle_to[2] = '{0, 8};

  function automatic int exp_dom(input int k);
    int r = 0;
    if (m_ph[k] == 0)
      for (int i = 0; i < N; i++)
        if (m_n[k] < HOLD + i * STAG) r |= (1 << i);
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_ph[k] = 0; m_idle[k] = 0; m_drn[k] = 0; m_st[k] = 0; m_fin[k] = 0; m_cc[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_n[k] = 0; m_ph[k] = 0; m_idle[k] = 0; m_drn[k] = 0; m_st[k] = 0; m_fin[k] = 0; m_cc[k] = 0;
        end else if (m_ph[k] == 0) begin
          m_n[k]++;
          if (m_n[k] >= RLAST) m_ph[k] = 1;
        end else if (m_ph[k] == 1) begin
          if (fail_i)       begin m_st[k] = 2; m_ph[k] = (DRAIN == 0) ? 3 : 2; end
          else if (done_i)  begin m_st[k] = 1; m_ph[k] = (DRAIN == 0) ? 3 : 2; end
          else if (m_cc[k] == MAXC) begin m_st[k] = 3; m_ph[k] = 3; end
          else if (idle_to[k] != 0 && m_idle[k] == idle_to[k]) begin m_st[k] = 3; m_ph[k] = 3; end
          if (m_cc[k] < CC_SAT) m_cc[k]++;
          m_idle[k] = kick_i ? 0 : m_idle[k] + 1;
          m_drn[k]  = 0;
          if (m_ph[k] == 3) m_fin[k] = 1;
        end else if (m_ph[k] == 2) begin
          if (fail_i && m_st[k] == 1) m_st[k] = 2;
          if (m_cc[k] < CC_SAT) m_cc[k]++;
          m_drn[k]++;
          if (m_drn[k] >= DRAIN) begin m_ph[k] = 3; m_fin[k] = 1; end
        end
      end
    end
  end

  task automatic cmp(input int k, input logic [N-1:0] dom, input logic [CW-1:0] cc,
                     input logic [1:0] st, input logic [1:0] stat, input logic fin);
    chk($sformatf("u%0d.dom_rst", k), dom, exp_dom(k));
    chk($sformatf("u%0d.cycle_count", k), cc, m_cc[k]);
    chk($sformatf("u%0d.state", k), st, m_ph[k]);
    chk($sformatf("u%0d.status", k), stat, m_st[k]);
    chk($sformatf("u%0d.finished", k), fin, m_fin[k]);
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0, b0.dom_rst, b0.cycle_count, b0.state, b0.status, b0.finished);
    cmp(1, b1.dom_rst, b1.cycle_count, b1.state, b1.status, b1.finished);
  end

  logic [3:0] rel [5] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

  task automatic apply_reset(input int hold);
    done_i = 0; fail_i = 0; kick_i = 0; rst = 1;
    repeat (hold) @(negedge clk);
    chk("rst.dom_rst", b0.dom_rst, 4'hF);
    chk("rst.state", b0.state, 0);
    chk("rst.status", b0.status, 0);
    chk("rst.finished", b0.finished, 0);
    chk("rst.cycle_count", b0.cycle_count, 0);
    rst = 0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      chk($sformatf("release.edge%0d", e + 1), b0.dom_rst, rel[e]);
    end
    chk("release.state", b0.state, 1);
    chk("release.cycle_count", b0.cycle_count, 0);
  endtask

  task automatic wait_cc(input longint target);
    int n = 0;
    while (b0.cycle_count != CW'(target) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL wait_cc: cycle_count %0d never reached %0d", b0.cycle_count, target);
    end
  endtask

  initial begin
    // Reset release then pass with drain
    apply_reset(3);
    wait_cc(10);
    done_i = 1; @(negedge clk); done_i = 0;
    chk("pass.state", b0.state, 2);
    chk("pass.status", b0.status, 1);
    chk("pass.cc_entry", b0.cycle_count, 11);
    repeat (3) @(negedge clk);
    chk("pass.still_drain", b0.state, 2);
    @(negedge clk);
    chk("pass.end", b0.state, 3);
    chk("pass.finished", b0.finished, 1);
    repeat (3) @(negedge clk);
    chk("pass.cc_frozen", b0.cycle_count, 15);
    chk("pass.dom_low", b0.dom_rst, 0);

    // done and fail together: fail wins
    apply_reset(1);
    wait_cc(5);
    done_i = 1; fail_i = 1; @(negedge clk); done_i = 0; fail_i = 0;
    chk("both.state", b0.state, 2);
    chk("both.status", b0.status, 2);
    repeat (4) @(negedge clk);
    chk("both.end", b0.state, 3);

    // fail during drain upgrades pass
    apply_reset(1);
    wait_cc(5);
    done_i = 1; @(negedge clk); done_i = 0;
    chk("upg.status_a", b0.status, 1);
    @(negedge clk);
    chk("upg.status_b", b0.status, 1);
    fail_i = 1; @(negedge clk); fail_i = 0;
    chk("upg.status_c", b0.status, 2);
    repeat (2) @(negedge clk);
    chk("upg.end", b0.state, 3);
    chk("upg.final_status", b0.status, 2);

    // global timeout straight to END
    apply_reset(1);
    wait_cc(100);
    chk("gto.run_at_max", b0.state, 1);
    @(negedge clk);
    chk("gto.end", b0.state, 3);
    chk("gto.status", b0.status, 3);
    chk("gto.finished", b0.finished, 1);

    // idle watchdog on the second instance
    apply_reset(1);
    for (int e = 1; e <= 50; e++) begin
      kick_i = (e % 5 == 0);
      @(negedge clk);
    end
    kick_i = 0;
    chk("idle.run_50", b1.state, 1);
    chk("idle.cc_50", b1.cycle_count, 50);
    repeat (8) @(negedge clk);
    chk("idle.run_8_after", b1.state, 1);
    @(negedge clk);
    chk("idle.end", b1.state, 3);
    chk("idle.status", b1.status, 3);

    // reset mid-run and in END
    apply_reset(1);
    wait_cc(40);
    apply_reset(1);
    wait_cc(3);
    done_i = 1; @(negedge clk); done_i = 0;
    repeat (5) @(negedge clk);
    chk("rend.in_end", b0.state, 3);
    apply_reset(1);

    // randomized traffic against the model
    for (int it = 0; it < 6; it++) begin
      apply_reset(1 + int'($urandom_range(0, 2)));
      for (int c = 0; c < 150; c++) begin
        done_i = ($urandom_range(0, 99) < 2);
        fail_i = ($urandom_range(0, 99) < 2);
        kick_i = ($urandom_range(0, 99) < 40);
        rst    = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      done_i = 0; fail_i = 0; kick_i = 0; rst = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tb_sequencer.md
Name: tb_sequencer

Overview:
- Parametrised clock-domain test sequencer for simulation benches; successor to the fixed reset/timeout generator.
- Takes the bench clock and a global reset, and releases NumResets per-domain resets in a staggered order.
- Runs a global cycle watchdog and an optional idle watchdog, collects pass/fail from the bench, drains, then signals end (optionally calls $finish).
- Core logic is synthesizable; the $finish hook is simulation-only.

Parameters:
- NumResets, 4, number of per-domain reset outputs (>=1).
- ResetHoldCycles, 2, edges with rst low before dom_rst[0] releases (>=1).
- ResetStagger, 1, extra edges between successive channel releases (>=0).
- CycleWidth, 32, width of cycle_count.
- MaxCycleCount, 1048576, RUN-state cycle limit before timeout (>=1).
- IdleTimeout, 0, RUN edges without kick before timeout; 0 disables.
- DrainCycles, 4, edges spent in DRAIN after pass/fail before END.
- FinishOnEnd, 1, 1 = $display status and $finish on first edge where finished=1.

Ports:
- clk  in  1  bench clock.
- rst  in  1  synchronous, active-high reset.
- test_done  in  1  bench reports completion (pass unless fail is also seen).
- test_fail  in  1  bench reports failure.
- kick  in  1  idle-watchdog kick.
- dom_rst  out  NumResets  per-domain active-high resets.
- cycle_count  out  CycleWidth  cycles elapsed since entering RUN.
- state  out  2  0 RESET, 1 RUN, 2 DRAIN, 3 END.
- status  out  2  0 running, 1 pass, 2 fail, 3 timeout.
- finished  out  1  high in END.

Behaviour:
- Reset values: rst high at an edge gives state=RESET, dom_rst=all 1, cycle_count=0, status=0, finished=0, internal seq/idle/drain counters=0. This applies from any state, including mid-RUN, DRAIN or END; dom_rst reasserts on that same edge.
- RESET state:
  - seq counter increments on each edge with rst low.
  - Let Ri = ResetHoldCycles + i*ResetStagger. dom_rst[i] falls on the Ri-th edge with rst low.
  - On the edge where the last channel falls, state becomes RUN.
  - test_done, test_fail and kick are ignored.
  - Release order is strictly by index. With ResetStagger=0, all channels fall on the same edge.
- RUN state:
  - cycle_count increments each edge.
  - Idle counter increments each edge; kick clears it to 0 on that edge.
  - Exit conditions are evaluated on the registered values at each edge, in priority order:
    1. test_fail: status=2, go to DRAIN.
    2. test_done: status=1, go to DRAIN.
    3. cycle_count==MaxCycleCount: status=3, go directly to END.
    4. IdleTimeout!=0 and idle==IdleTimeout: status=3, go to END.
  - If DrainCycles==0, the fail/done branches go straight to END.
- DRAIN state:
  - Drain counter counts DrainCycles edges; END is entered on the DrainCycles-th edge.
  - cycle_count keeps counting.
  - test_fail while status=1 upgrades status to 2.
  - test_done, kick and the watchdogs are ignored.
- END state:
  - finished=1, registered on the entry edge.
  - All outputs frozen; dom_rst stays 0.
  - Only rst exits END.
- cycle_count saturates at all-ones and never wraps.
- MaxCycleCount must be <= 2^CycleWidth-1; this is checked by an elaboration-time assertion.
- status is written only on state transitions or the DRAIN upgrade; it is never 0 in END.
- FinishOnEnd=1: a simulation-only process prints status and cycle_count, then calls $finish on the first edge where finished=1.

Test Plan:
Defaults for all scenarios: NumResets=4, ResetHoldCycles=2, ResetStagger=1, MaxCycleCount=100, DrainCycles=4, IdleTimeout=0, FinishOnEnd=0.
- Reset release: rst high 3 edges, then low. Required: dom_rst goes 1111, 1110, 1100, 1000, 0000 on low-edges 2..5 (1111 holds through low-edge 1). state=RUN after edge 5, cycle_count=0.
- Pass with drain: pulse test_done at cycle_count=10. Required: status=1, state=DRAIN; END after 4 edges with finished=1; cycle_count frozen at 15.
- Fail priority and upgrade: test_done and test_fail together in RUN gives status=2. Separately, test_done then test_fail 2 edges later in DRAIN gives status 1 then 2.
- Global timeout: no inputs. Required: at cycle_count=100, state goes to END on that edge, status=3, no DRAIN.
- Idle watchdog (IdleTimeout=8): kick every 5 edges keeps RUN to 50 cycles; stopping kicks gives END with status=3 after 8 more edges.
- Reset mid-run and in END: rst at cycle_count=40, and again in END. Required: next edge all dom_rst=1, status=0, finished=0, cycle_count=0, and the release sequence repeats exactly.
